// File: rtl/artemis_ddr3_port_arbiter.sv
// Round-robin command front end for one DDR3 native user port.
// Splits whole-transfer client requests into bursts of at most MAX_BL words.
module artemis_ddr3_port_arbiter #(
    parameter  int CHANNELS = 4,
    parameter  int ADDR_W   = 30,
    parameter  int LEN_W    = 16,
    parameter  int MAX_BL   = 64,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        req_valid,
    input  logic [CHANNELS-1:0]        req_write,
    input  logic [CHANNELS*ADDR_W-1:0] req_addr,
    input  logic [CHANNELS*LEN_W-1:0]  req_len,
    output logic [CHANNELS-1:0]        req_ready,
    output logic [CHANNELS-1:0]        done,
    output logic                       busy,
    output logic                       cmd_en,
    output logic [2:0]                 cmd_instr,
    output logic [5:0]                 cmd_bl,
    output logic [ADDR_W-1:0]          cmd_byte_addr,
    input  logic                       cmd_full,
    output logic [CW-1:0]              cmd_chan
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_last;
    logic [CW-1:0]       r_chan;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;

    logic [CW-1:0]       w_grant;
    logic [CW-1:0]       w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_issue;
    logic                w_fire;
    logic                w_done;
    logic [6:0]          w_chunk;

    // Round-robin scan starting just after the last granted channel
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            w_idx = CW'((int'(r_last) + i) % CHANNELS);
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Burst sizing, issue and completion decode
    always_comb begin
        w_issue  = (r_state == S_ISSUE);
        w_accept = (r_state == S_IDLE) && w_any && !rst;
        if (r_rem < LEN_W'(MAX_BL))
            w_chunk = 7'(r_rem);
        else
            w_chunk = 7'(MAX_BL);
        w_fire = w_issue && (r_rem != '0) && !cmd_full;
        w_done = w_issue &&
                 ((r_rem == '0) || (w_fire && (r_rem == LEN_W'(w_chunk))));
    end

    // Output drive; everything except req_ready is zero outside ISSUE
    always_comb begin
        req_ready     = w_accept ? (CHANNELS'(1) << w_grant) : '0;
        done          = w_done ? (CHANNELS'(1) << r_chan) : '0;
        busy          = w_issue;
        cmd_en        = w_fire;
        cmd_instr     = w_issue ? {2'b00, !r_write} : 3'b000;
        cmd_bl        = w_issue ? 6'(w_chunk - 7'd1) : 6'd0;
        cmd_byte_addr = w_issue ? r_addr : '0;
        cmd_chan      = w_issue ? r_chan : '0;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (w_done)   w_next = S_IDLE;
        endcase
    end

    // Request latch on accept; address/remaining advance per burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= CW'(CHANNELS - 1);
            r_chan  <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_last  <= w_grant;
            r_chan  <= w_grant;
            r_write <= req_write[w_grant];
            r_addr  <= {req_addr[int'(w_grant)*ADDR_W+2 +: ADDR_W-2], 2'b00};
            r_rem   <= req_len[int'(w_grant)*LEN_W +: LEN_W];
        end else if (w_fire) begin
            r_addr  <= r_addr + ADDR_W'({w_chunk, 2'b00});
            r_rem   <= r_rem - LEN_W'(w_chunk);
        end
    end

endmodule

// File: tb/tb_artemis_ddr3_port_arbiter.sv
// Directed bench for artemis_ddr3_port_arbiter with a command/done scoreboard.
// Default parameters: 4 channels, 30-bit address, 16-bit length, MAX_BL 64.
module tb_artemis_ddr3_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int LW = 16;
    localparam int BL = 64;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    done;
    logic            busy;
    logic            cmd_en;
    logic [2:0]      cmd_instr;
    logic [5:0]      cmd_bl;
    logic [AW-1:0]   cmd_byte_addr;
    logic            cmd_full;
    logic [1:0]      cmd_chan;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    int          done_q[$];

    artemis_ddr3_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .done(done), .busy(busy),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .cmd_chan(cmd_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference burst split pushed into the scoreboard
    task automatic set_req(input int ch, input bit wr,
                           input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ad;
        int rem;
        int c;
        req_valid[ch]          = 1'b1;
        req_write[ch]          = wr;
        req_addr[ch*AW +: AW]  = a;
        req_len[ch*LW +: LW]   = LW'(len);
        ad  = {a[AW-1:2], 2'b00};
        rem = len;
        while (rem > 0) begin
            c = (rem > BL) ? BL : rem;
            exp_q.push_back({21'd0, 4'(ch), wr ? 3'b000 : 3'b001,
                             6'(c - 1), ad});
            ad  = ad + AW'(c * 4);
            rem = rem - c;
        end
        done_q.push_back(ch);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every issued command and done strobe is popped
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_en) begin
                chk("sb_cmd_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    chk("sb_cmd", {21'd0, 2'b00, cmd_chan, cmd_instr,
                                   cmd_bl, cmd_byte_addr},
                        exp_q.pop_front());
            end
            if (done != '0) begin
                chk("sb_done_pending", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0)
                    chk("sb_done", 64'(done),
                        64'(4'b0001 << done_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_len   = '0;
        cmd_full  = 1'b0;
        #2;
        req_valid[0] = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_en", 64'(cmd_en), 64'd0);
        chk("rst_bl", 64'(cmd_bl), 64'd0);
        chk("rst_addr", 64'(cmd_byte_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Single transfer split into 64 + 36 words
        tick();
        set_req(0, 1'b1, 30'h1000, 100);
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        chk("t1_busy0", 64'(busy), 64'd0);
        tick();
        req_valid = '0;
        #1;
        chk("t1_busy1", 64'(busy), 64'd1);
        chk("t1_en1", 64'(cmd_en), 64'd1);
        chk("t1_bl1", 64'(cmd_bl), 64'd63);
        chk("t1_addr1", 64'(cmd_byte_addr), 64'h1000);
        chk("t1_instr", 64'(cmd_instr), 64'd0);
        chk("t1_done1", 64'(done), 64'd0);
        tick();
        #1;
        chk("t1_en2", 64'(cmd_en), 64'd1);
        chk("t1_bl2", 64'(cmd_bl), 64'd35);
        chk("t1_addr2", 64'(cmd_byte_addr), 64'h1100);
        chk("t1_done2", 64'(done), 64'h1);
        tick();
        #1;
        chk("t1_busy_end", 64'(busy), 64'd0);

        // Back-pressure on a 200-word read
        tick();
        set_req(1, 1'b0, 30'h2002, 200);
        #1;
        chk("t2_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        #1;
        chk("t2_en1", 64'(cmd_en), 64'd1);
        chk("t2_addr1", 64'(cmd_byte_addr), 64'h2000);
        chk("t2_instr", 64'(cmd_instr), 64'd1);
        chk("t2_chan", 64'(cmd_chan), 64'd1);
        tick();
        cmd_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            chk("t2_stall_en", 64'(cmd_en), 64'd0);
            chk("t2_stall_addr", 64'(cmd_byte_addr), 64'h2100);
            chk("t2_stall_bl", 64'(cmd_bl), 64'd63);
            chk("t2_stall_done", 64'(done), 64'd0);
        end
        tick();
        cmd_full = 1'b0;
        #1;
        chk("t2_en2", 64'(cmd_en), 64'd1);
        chk("t2_addr2", 64'(cmd_byte_addr), 64'h2100);
        chk("t2_done2", 64'(done), 64'd0);
        tick();
        #1;
        chk("t2_addr3", 64'(cmd_byte_addr), 64'h2200);
        chk("t2_bl3", 64'(cmd_bl), 64'd63);
        tick();
        #1;
        chk("t2_addr4", 64'(cmd_byte_addr), 64'h2300);
        chk("t2_bl4", 64'(cmd_bl), 64'd7);
        chk("t2_done4", 64'(done), 64'h2);
        tick();
        #1;
        chk("t2_busy_end", 64'(busy), 64'd0);

        // Zero-length request
        tick();
        set_req(1, 1'b1, 30'h3000, 0);
        #1;
        chk("z_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        #1;
        chk("z_done", 64'(done), 64'h2);
        chk("z_en", 64'(cmd_en), 64'd0);
        chk("z_busy", 64'(busy), 64'd1);
        tick();
        #1;
        chk("z_idle", 64'(busy), 64'd0);
        chk("z_done_off", 64'(done), 64'd0);

        // Reset during the second burst of a 256-word read
        tick();
        set_req(2, 1'b0, 30'h4000, 256);
        #1;
        chk("r_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        #1;
        chk("r_en1", 64'(cmd_en), 64'd1);
        tick();
        #1;
        chk("r_addr2", 64'(cmd_byte_addr), 64'h4100);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        #1;
        chk("r_en", 64'(cmd_en), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_instr", 64'(cmd_instr), 64'd0);
        chk("r_bl", 64'(cmd_bl), 64'd0);
        chk("r_addr", 64'(cmd_byte_addr), 64'd0);
        chk("r_chan", 64'(cmd_chan), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 30'h5000, 1);
        set_req(3, 1'b0, 30'h5100, 1);
        #1;
        chk("r_grant0", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("r_done0", 64'(done), 64'h1);
        tick();
        #1;
        chk("r_grant3", 64'(req_ready), 64'h8);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("r_done3", 64'(done), 64'h8);
        tick();
        #1;
        chk("r_idle", 64'(busy), 64'd0);

        // Round robin over all four channels
        tick();
        for (int c = 0; c < N; c++)
            set_req(c, c[0], AW'(c * 'h40), 1);
        for (int k = 0; k < N; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), 64'(4'b0001 << k));
            tick();
            req_valid[k] = 1'b0;
            #1;
            chk("rr_done", 64'(done), 64'(4'b0001 << k));
            chk("rr_en", 64'(cmd_en), 64'd1);
            tick();
        end
        #1;
        chk("rr_idle", 64'(busy), 64'd0);
        set_req(0, 1'b1, 30'h600, 1);
        set_req(2, 1'b1, 30'h700, 1);
        #1;
        chk("rr2_first", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        tick();
        #1;
        chk("rr2_second", 64'(req_ready), 64'h4);
        tick();
        req_valid[2] = 1'b0;
        #1;
        tick();

        // Address wrap at 2^30
        set_req(2, 1'b1, 30'h3FFF_FFF0, 68);
        #1;
        chk("w_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        #1;
        chk("w_addr1", 64'(cmd_byte_addr), 64'h3FFF_FFF0);
        chk("w_bl1", 64'(cmd_bl), 64'd63);
        tick();
        #1;
        chk("w_addr2", 64'(cmd_byte_addr), 64'h0000_00F0);
        chk("w_bl2", 64'(cmd_bl), 64'd3);
        chk("w_done", 64'(done), 64'h4);
        tick();
        #1;
        chk("w_idle", 64'(busy), 64'd0);

        tick();
        chk("sb_cmd_empty", 64'(exp_q.size()), 64'd0);
        chk("sb_done_empty", 64'(done_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/artemis_ddr3_port_arbiter.md
# artemis_ddr3_port_arbiter

Parametrised N-channel command front end for one DDR3 native user port. It accepts whole-transfer requests (direction, byte address, word count) from CHANNELS clients. It arbitrates between them round-robin and splits each transfer into bursts of at most MAX_BL 32-bit words. Each burst is issued on the port's cmd_en/cmd_instr/cmd_bl/cmd_byte_addr interface under cmd_full back-pressure. It sits between the DMA/host clients and one port (p0..p3) of the DDR3 controller wrapper, in that port's command clock domain.

## Interface
- CHANNELS, 4: number of requesting clients, 1..16.
- ADDR_W, 30: byte address width.
- LEN_W, 16: request length field width, in 32-bit words.
- MAX_BL, 64: maximum words per issued burst, 1..64.
- clk  in  1  port command clock; all logic is on this single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  CHANNELS  per-channel request pending.
- req_write  in  CHANNELS  1 = write, 0 = read.
- req_addr  in  CHANNELS*ADDR_W  start byte address, channel i at [i*ADDR_W +: ADDR_W]; bits [1:0] are ignored and treated as 0.
- req_len  in  CHANNELS*LEN_W  transfer length in words; 0 is legal.
- req_ready  out  CHANNELS  one-hot accept strobe.
- done  out  CHANNELS  one-hot, one-cycle completion strobe.
- busy  out  1  high whenever state is not IDLE.
- cmd_en  out  1  command strobe to the controller port.
- cmd_instr  out  3  3'b000 = write, 3'b001 = read.
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  ADDR_W  burst start byte address.
- cmd_full  in  1  controller command FIFO full.
- cmd_chan  out  max(1,$clog2(CHANNELS))  index of the channel that owns the current command, used to steer wr/rd data.

## Operation
- **States:** IDLE, ISSUE.
- **IDLE, arbitration:**
  - When any req_valid is high, grant the first valid channel found scanning from last_grant+1 upward, modulo CHANNELS.
  - req_ready[grant] is combinational, high only in IDLE.
  - A request is accepted when req_valid and req_ready are both high on a clock edge.
  - On acceptance, latch direction, word-aligned address, length and channel into cur_*; set last_grant = grant; go to ISSUE.
- **Request withdrawal:** a client may drop req_valid before it is accepted. Once accepted, the request's inputs are don't-care.
- **ISSUE, burst issue:**
  - chunk = min(remaining, MAX_BL).
  - cmd_en = (remaining != 0) && !cmd_full. It is combinational, with no registered delay.
  - cmd_bl = chunk-1, cmd_byte_addr = cur_addr, cmd_instr from cur_write, cmd_chan = cur_chan. These are valid throughout ISSUE.
  - On an edge with cmd_en high: cur_addr += chunk*4, modulo 2^ADDR_W; remaining -= chunk.
- **ISSUE, completion:**
  - If a burst fires and remaining-chunk == 0: done[cur_chan] is high in that same cycle, and the next state is IDLE.
  - If remaining == 0 on entry (zero-length request): no cmd_en; done[cur_chan] is high for one cycle; next state is IDLE.
- **Back-pressure:** while cmd_full is high, cmd_en stays low and cur_addr/remaining hold. Outputs stay stable.
- **Arithmetic:** remaining is LEN_W bits and never underflows. The address wraps silently at 2^ADDR_W.
- **Reset:**
  - On rst assertion, immediately: state = IDLE, last_grant = CHANNELS-1 (so channel 0 has first priority), all cur_* registers = 0.
  - All outputs reset to 0: req_ready, done, busy, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_chan.
  - Reset mid-transfer abandons the request with no done.

## Timing
- **Acceptance cycle T:** req_ready is high; busy rises at T+1.
- **First cmd_en:** earliest at T+1.
- **Consecutive bursts:** one burst per cycle while cmd_full is low.
- **Final burst:** final cmd_en and done coincide in cycle D; IDLE at D+1.
- **Next request:** can be accepted at D+1, with its first cmd_en at D+2.
- **Zero-length request:** accepted at T, done at T+1.
- **Issue latency:** a transfer of L > 0 words with no back-pressure occupies ceil(L/MAX_BL) ISSUE cycles.
- **Throughput:** minimum gap between transfers is one idle cycle (the arbitration cycle).

## Test plan
- **Single transfer split:** MAX_BL=64; ch0 write, addr 0x1000, len 100 → cmd_en at T+1 with bl=63, addr 0x1000, instr 000; then T+2 with bl=35, addr 0x1100; done[0] at T+2; busy low at T+3.
- **Back-pressure:** ch1 read, len 200; hold cmd_full high for 5 cycles after the first burst → cmd_en low for those cycles with addr/bl frozen; bursts resume with bl 63, 63, 7; done[1] only on the last burst.
- **Round-robin fairness:** all four req_valid high, len 1 each → accepts in order 0,1,2,3, spaced 2 cycles apart. Then ch0 and ch2 re-request → ch0 granted before ch2.
- **Zero length:** ch1, len 0 → req_ready[1] at T, done[1] at T+1, no cmd_en.
- **Address wrap:** MAX_BL=4; addr 0x3FFF_FFF0, len 8 → bursts at 0x3FFF_FFF0 and 0x0000_0000, both bl=3.
- **Reset mid-transfer:** assert rst during the second burst of a len 256 transfer → all outputs 0 asynchronously and no done. After release with ch0 and ch3 both valid, ch0 is granted first.
